// File: rtl/fu_mul_sequencer_if.sv
// Bundle between the execute stage, the multiply sequencer and the shared function unit.
// The master side owns the pipeline operands, the multiply request and the function-unit result.
interface fu_mul_sequencer_if;
    logic [31:0] pipe_A;
    logic [31:0] pipe_B;
    logic [4:0]  pipe_FS;
    logic [4:0]  pipe_SH;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] fu_F;
    logic        fu_C;
    logic [31:0] fu_A;
    logic [31:0] fu_B;
    logic [4:0]  fu_FS;
    logic [4:0]  fu_SH;
    logic        pipe_stall;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        mul_ovf;

    modport master (
        output pipe_A, pipe_B, pipe_FS, pipe_SH,
        output mul_start, mul_a, mul_b,
        output fu_F, fu_C,
        input  fu_A, fu_B, fu_FS, fu_SH,
        input  pipe_stall, mul_busy, mul_done, mul_result, mul_ovf
    );

    modport slave (
        input  pipe_A, pipe_B, pipe_FS, pipe_SH,
        input  mul_start, mul_a, mul_b,
        input  fu_F, fu_C,
        output fu_A, fu_B, fu_FS, fu_SH,
        output pipe_stall, mul_busy, mul_done, mul_result, mul_ovf
    );
endinterface

// File: rtl/fu_mul_sequencer.sv
// Shift-and-add 32x32 multiplier (low word) that borrows the execute-stage function unit.
// state | meaning
// IDLE  | function unit passes pipeline operands through; accepts mul_start
// STEP  | inspect multiplier LSB: add partial product, shift, or finish
// SHIFT | shift multiplicand left by one, multiplier right by one
// DONE  | result valid for one cycle; pass-through resumes
module fu_mul_sequencer #(
    parameter logic [4:0] FS_ADD = 5'b10010,
    parameter logic [4:0] FS_SHL = 5'b00100
) (
    input logic clk,
    input logic rst,
    fu_mul_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mcand;
    logic [31:0] mcand_nxt;
    logic [31:0] mplier;
    logic [31:0] mplier_nxt;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic        ovf;
    logic        ovf_nxt;
    logic [31:0] result_q;
    logic        ovf_q;
    logic        load_result;
    logic        shift_ovf;

    // A multiplicand bit leaving bit 31 is lost product only if a higher multiplier bit remains.
    assign shift_ovf = ovf | (mcand[31] & (mplier[31:1] != 31'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= 32'd0;
            mplier   <= 32'd0;
            acc      <= 32'd0;
            ovf      <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            ovf    <= ovf_nxt;
            if (load_result) begin
                result_q <= acc;
                ovf_q    <= ovf;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        acc_nxt     = acc;
        ovf_nxt     = ovf;
        load_result = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mul_start) begin
                    mcand_nxt  = bus.mul_a;
                    mplier_nxt = bus.mul_b;
                    acc_nxt    = 32'd0;
                    ovf_nxt    = 1'b0;
                    state_nxt  = STEP;
                end
            end
            STEP: begin
                if (mplier == 32'd0) begin
                    // Capture here so the result is already visible during DONE.
                    load_result = 1'b1;
                    state_nxt   = DONE;
                end else if (mplier[0]) begin
                    acc_nxt   = bus.fu_F;
                    ovf_nxt   = ovf | bus.fu_C;
                    state_nxt = SHIFT;
                end else begin
                    mcand_nxt  = bus.fu_F;
                    mplier_nxt = mplier >> 1;
                    ovf_nxt    = shift_ovf;
                end
            end
            SHIFT: begin
                mcand_nxt  = bus.fu_F;
                mplier_nxt = mplier >> 1;
                ovf_nxt    = shift_ovf;
                state_nxt  = STEP;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Kept apart from the next-state logic: fu_F depends on these drives.
    always_comb begin
        bus.fu_A       = bus.pipe_A;
        bus.fu_B       = bus.pipe_B;
        bus.fu_FS      = bus.pipe_FS;
        bus.fu_SH      = bus.pipe_SH;
        bus.pipe_stall = 1'b0;
        case (state)
            STEP: begin
                bus.pipe_stall = 1'b1;
                if (mplier == 32'd0 || mplier[0]) begin
                    bus.fu_A  = acc;
                    bus.fu_B  = (mplier == 32'd0) ? 32'd0 : mcand;
                    bus.fu_FS = FS_ADD;
                    bus.fu_SH = 5'd0;
                end else begin
                    bus.fu_A  = mcand;
                    bus.fu_B  = 32'd0;
                    bus.fu_FS = FS_SHL;
                    bus.fu_SH = 5'd1;
                end
            end
            SHIFT: begin
                bus.pipe_stall = 1'b1;
                bus.fu_A       = mcand;
                bus.fu_B       = 32'd0;
                bus.fu_FS      = FS_SHL;
                bus.fu_SH      = 5'd1;
            end
            default: begin
                bus.pipe_stall = 1'b0;
            end
        endcase
    end

    assign bus.mul_busy   = (state != IDLE);
    assign bus.mul_done   = (state == DONE);
    assign bus.mul_result = result_q;
    assign bus.mul_ovf    = ovf_q;

endmodule

// File: tb/tb_fu_mul_sequencer.sv
// Randomized and directed checks of the multiply sequencer against an arithmetic reference.
// The bench also plays the function unit (add and logical shift-left).
module tb_fu_mul_sequencer;

    localparam logic [4:0] FS_ADD = 5'b10010;
    localparam logic [4:0] FS_SHL = 5'b00100;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] held;

    fu_mul_sequencer_if bus();

    fu_mul_sequencer #(.FS_ADD(FS_ADD), .FS_SHL(FS_SHL)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural function unit
    always_comb begin
        bus.fu_F = bus.fu_A ^ bus.fu_B;
        bus.fu_C = 1'b0;
        if (bus.fu_FS == FS_ADD)
            {bus.fu_C, bus.fu_F} = {1'b0, bus.fu_A} + {1'b0, bus.fu_B};
        else if (bus.fu_FS == FS_SHL)
            bus.fu_F = bus.fu_A << bus.fu_SH;
    end

    function automatic int msb_len(input logic [31:0] v);
        for (int i = 31; i >= 0; i--)
            if (v[i]) return i + 1;
        return 0;
    endfunction

    task automatic randomize_pipe();
        bus.pipe_A  = $urandom;
        bus.pipe_B  = $urandom;
        bus.pipe_FS = 5'($urandom);
        bus.pipe_SH = 5'($urandom);
    endtask

    task automatic check_pass(input string tag);
        n_checks++;
        if (bus.fu_A !== bus.pipe_A || bus.fu_B !== bus.pipe_B ||
            bus.fu_FS !== bus.pipe_FS || bus.fu_SH !== bus.pipe_SH || bus.pipe_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL %s passthrough: got A=%h B=%h FS=%b SH=%0d stall=%b expected A=%h B=%h FS=%b SH=%0d stall=0",
                     tag, bus.fu_A, bus.fu_B, bus.fu_FS, bus.fu_SH, bus.pipe_stall,
                     bus.pipe_A, bus.pipe_B, bus.pipe_FS, bus.pipe_SH);
        end
    endtask

    // Runs one multiply; optionally pulses a second start at cycle t+pulse_at.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                           input logic [31:0] pa, input logic [31:0] pb, input string tag);
        int          exp_lat;
        int          lat;
        logic [63:0] prod;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [4:0]  efs;
        logic [4:0]  esh;
        exp_lat = 2 + $countones(b) + msb_len(b);
        prod    = {32'd0, a} * {32'd0, b};
        @(negedge clk);
        n_checks++;
        if (bus.mul_busy !== 1'b0 || bus.mul_result !== held) begin
            n_errors++;
            $display("FAIL %s idle_hold: got busy=%b result=%h expected busy=0 result=%h",
                     tag, bus.mul_busy, bus.mul_result, held);
        end
        bus.mul_start = 1'b1;
        bus.mul_a     = a;
        bus.mul_b     = b;
        lat = 0;
        for (int k = 1; k <= 80 && lat == 0; k++) begin
            @(negedge clk);
            bus.mul_start = (k == pulse_at);
            if (k == pulse_at) begin
                bus.mul_a = pa;
                bus.mul_b = pb;
            end
            randomize_pipe();
            #1;
            if (k == 1) begin
                if (b == 32'd0) begin
                    ea = 32'd0; eb = 32'd0; efs = FS_ADD; esh = 5'd0;
                end else if (b[0]) begin
                    ea = 32'd0; eb = a; efs = FS_ADD; esh = 5'd0;
                end else begin
                    ea = a; eb = 32'd0; efs = FS_SHL; esh = 5'd1;
                end
                n_checks++;
                if (bus.fu_A !== ea || bus.fu_B !== eb || bus.fu_FS !== efs || bus.fu_SH !== esh) begin
                    n_errors++;
                    $display("FAIL %s first_step_fu: got A=%h B=%h FS=%b SH=%0d expected A=%h B=%h FS=%b SH=%0d",
                             tag, bus.fu_A, bus.fu_B, bus.fu_FS, bus.fu_SH, ea, eb, efs, esh);
                end
            end
            if (bus.mul_done === 1'b1) begin
                lat = k;
            end else begin
                n_checks++;
                if (bus.pipe_stall !== 1'b1 || bus.mul_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s busy_stall t+%0d: got stall=%b busy=%b expected 1 1",
                             tag, k, bus.pipe_stall, bus.mul_busy);
                end
            end
        end
        bus.mul_start = 1'b0;
        n_checks++;
        if (lat != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d expected %0d (0 means no done pulse)", tag, lat, exp_lat);
        end
        n_checks++;
        if (bus.mul_result !== prod[31:0]) begin
            n_errors++;
            $display("FAIL %s result: got %h expected %h", tag, bus.mul_result, prod[31:0]);
        end
        n_checks++;
        if (bus.mul_ovf !== (prod[63:32] != 32'd0)) begin
            n_errors++;
            $display("FAIL %s ovf: got %b expected %b", tag, bus.mul_ovf, prod[63:32] != 32'd0);
        end
        n_checks++;
        if (bus.mul_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done_busy: got %b expected 1", tag, bus.mul_busy);
        end
        check_pass({tag, " done"});
        held = prod[31:0];
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.mul_start = 1'b0;
        bus.mul_a     = 32'd0;
        bus.mul_b     = 32'd0;
        bus.pipe_A    = 32'd7;
        bus.pipe_B    = 32'd9;
        bus.pipe_FS   = 5'b10010;
        bus.pipe_SH   = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_pass("reset");
        n_checks++;
        if (bus.mul_busy !== 1'b0 || bus.mul_done !== 1'b0 || bus.mul_result !== 32'd0 || bus.mul_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h ovf=%b expected 0 0 0 0",
                     bus.mul_busy, bus.mul_done, bus.mul_result, bus.mul_ovf);
        end
        held = 32'd0;
    endtask

    task automatic test_directed();
        run_mul(32'd3, 32'd5, 0, 32'd0, 32'd0, "mul_3x5");
        run_mul(32'h1234, 32'd0, 0, 32'd0, 32'd0, "mul_by_zero");
        run_mul(32'h0001_0000, 32'h0001_0000, 0, 32'd0, 32'd0, "mul_ovf");
        run_mul(32'hFFFF_FFFF, 32'd1, 0, 32'd0, 32'd0, "mul_ones_x1");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 32'd0, "mul_max");
    endtask

    task automatic test_ignored_start();
        run_mul(32'd3, 32'd5, 3, 32'd7, 32'd11, "ignored_start");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.mul_start = 1'b1;
        bus.mul_a     = 32'd3;
        bus.mul_b     = 32'd5;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.mul_start = 1'b0;
            rst = (k == 4);
            n_checks++;
            if (bus.mul_done !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid no_done t+%0d: got %b expected 0", k, bus.mul_done);
            end
        end
        n_checks++;
        if (bus.mul_busy !== 1'b0 || bus.mul_result !== 32'd0 || bus.mul_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid state: got busy=%b result=%h ovf=%b expected 0 0 0",
                     bus.mul_busy, bus.mul_result, bus.mul_ovf);
        end
        check_pass("reset_mid");
        held = 32'd0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(16, 31);
            run_mul(a, b, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 4) : 0, $urandom, $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_mul(32'd6, 32'd7, 0, 32'd0, 32'd0, "b2b_0");
        run_mul(32'd1000, 32'd1000, 0, 32'd0, 32'd0, "b2b_1");
        run_mul(32'h8000_0000, 32'd2, 0, 32'd0, 32'd0, "b2b_2");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        held     = 32'd0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fu_mul_sequencer.md
Name: fu_mul_sequencer

Overview:
- Multi-cycle unsigned 32x32 multiplier (low 32 bits of the product) built as a shift-and-add sequence on the execute-stage function unit; no dedicated multiplier array.
- Arbitrates the single function unit between the pipeline's normal execute path and the multiply sequence, and stalls the pipeline while it owns the unit.
- Sits between the execute-stage operand/FS decode and the function unit inputs.

Parameters:
- FS_ADD, 5'b10010, function-select code for F = A + B (ALU path, C valid).
- FS_SHL, 5'b00100, function-select code for F = A shifted left logically by SH (shifter path).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_A  in  32  pipeline operand A.
- pipe_B  in  32  pipeline operand B.
- pipe_FS  in  5  pipeline function select.
- pipe_SH  in  5  pipeline shift amount.
- mul_start  in  1  multiply request; sampled only in IDLE.
- mul_a  in  32  multiplicand, latched on accepted start.
- mul_b  in  32  multiplier, latched on accepted start.
- fu_F  in  32  function unit result.
- fu_C  in  1  function unit carry.
- fu_A  out  32  function unit operand A.
- fu_B  out  32  function unit operand B.
- fu_FS  out  5  function unit select.
- fu_SH  out  5  function unit shift amount.
- pipe_stall  out  1  pipeline must hold; function unit is owned by the sequencer.
- mul_busy  out  1  sequence in progress (state != IDLE).
- mul_done  out  1  one-cycle pulse; result valid.
- mul_result  out  32  product, low 32 bits; held until next accepted start.
- mul_ovf  out  1  sticky per operation; set if the true product exceeds 32 bits.

Behaviour:
- Registers: state, mcand[31:0], mplier[31:0], acc[31:0], ovf.
- Reset: state = IDLE; mcand, mplier, acc, mul_result = 0; mul_ovf = 0; mul_done = 0. Reset mid-operation aborts with no done pulse.
- IDLE:
  - fu_* = pipe_* (combinational pass-through); pipe_stall = 0.
  - On mul_start: mcand <= mul_a, mplier <= mul_b, acc <= 0, ovf <= 0; next state STEP.
- STEP: pipe_stall = 1.
  - If mplier == 0: next DONE; fu_* driven to {acc, 0, FS_ADD, 0}; no register update.
  - Else if mplier[0] == 1: fu_A = acc, fu_B = mcand, fu_FS = FS_ADD, fu_SH = 0; acc <= fu_F; ovf |= fu_C; next SHIFT.
  - Else: perform the SHIFT action below and stay in STEP.
- SHIFT action (in SHIFT state, or in STEP with mplier[0] == 0):
  - Drive fu_A = mcand, fu_B = 0, fu_FS = FS_SHL, fu_SH = 1.
  - mcand <= fu_F; mplier <= mplier >> 1.
  - ovf |= mcand[31] & ((mplier >> 1) != 0).
  - SHIFT state: pipe_stall = 1; next STEP.
- DONE:
  - mul_done = 1; mul_result <= acc (registered, visible from the DONE cycle onward); mul_ovf <= ovf.
  - fu_* pass-through resumes; pipe_stall = 0; next IDLE.
- mul_busy = 1 in STEP, SHIFT, DONE.
- mul_start outside IDLE is ignored; it is not queued.
- Latency: start accepted at cycle t gives DONE at t + 2 + popcount(mul_b) + L, where L = index of the highest set bit of mul_b + 1 (L = 0 for mul_b = 0).
- Arithmetic is modulo 2^32; mul_result equals (mul_a * mul_b) mod 2^32.

Test Plan:
- Reset, then hold mul_start = 0 with pipe_A = 7, pipe_B = 9, pipe_FS = 5'b10010 -> fu_* equal the pipe_* values; pipe_stall = 0, mul_busy = 0, mul_result = 0.
- Start with a = 3, b = 5 at t -> STEP/SHIFT at t+1..t+6, pipe_stall = 1 throughout; mul_done at t+7; mul_result = 15, mul_ovf = 0.
- Start with a = 0x1234, b = 0 -> mul_done at t+2; mul_result = 0; FS_ADD/FS_SHL never issued with nonzero mplier.
- Start with a = 0x00010000, b = 0x00010000 -> mul_done at t+20; mul_result = 0, mul_ovf = 1. Then start with a = 0xFFFFFFFF, b = 1 -> result 0xFFFFFFFF, mul_ovf = 0.
- Pulse mul_start again at t+3 during the 3 x 5 operation with different operands -> ignored; result still 15 at t+7.
- Assert rst at t+4 of the 3 x 5 operation -> next cycle state IDLE, mul_result = 0, no mul_done pulse, pass-through restored.
